dmem_responder: RTL and testbench

- Word-addressed data memory: the target end of the CPU's CEN/WEN/OEN/A data-memory interface.
- After reset, runs a boot-load phase that fills the array over a valid/ready stream while holding the CPU off via cpu_hold.
- Then serves single-cycle CPU reads (combinational) and writes (committed at the clock edge).
- Keeps saturating read and write access counters for bench and performance checks.

---
 rtl/dmem_responder_if.sv | 37 +++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data-memory bus plus boot-load stream bundle
//
// Purpose: groups the CPU's CEN/WEN/OEN/A/D/Q data-memory signals and the
// boot-load valid/ready stream that fills the memory before the CPU runs.
// Ports (signals):
//   CEN, WEN, OEN       CPU strobes, active low (WEN=0 write, WEN=1 read)
//   A [ADDR_W]          CPU word address
//   D [32] / Q [32]     CPU write data / read data
//   load_valid/ready    boot-load handshake
//   load_data [32]      boot-load word
//   load_last           marks the final boot-load word
// Modports: master = CPU/loader side, slave = memory responder.

interface dmem_responder_if #(
  parameter int ADDR_W = 7
);
  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [31:0]       D;
  logic [31:0]       Q;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_ready;

  modport master (
    output CEN, WEN, OEN, A, D, load_valid, load_data, load_last,
    input  Q, load_ready
  );

  modport slave (
    input  CEN, WEN, OEN, A, D, load_valid, load_data, load_last,
    output Q, load_ready
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory with boot-load phase
//
// Purpose: target end of the CPU data-memory interface. After reset it
// accepts a boot image over the load stream while holding the CPU in reset,
// then serves zero-latency reads and edge-committed writes, counting both.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset (clears the whole array)
//   bus       dmem_responder_if.slave: CPU bus and boot-load stream
//   cpu_hold  1 while the CPU must be held in reset
//   rd_count  saturating count of serviced reads
//   wr_count  saturating count of serviced writes (dropped ones included)

module dmem_responder #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              cpu_hold,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       mem [DEPTH];

  logic in_range;
  logic load_acc;
  logic load_end;
  logic cpu_wr;
  logic cpu_rd;

  // One extra bit so the bound still compares correctly when DEPTH == 2^ADDR_W.
  assign in_range = ({1'b0, bus.A} < (ADDR_W+1)'(DEPTH));
  assign load_acc = (state == LOAD) && bus.load_valid;
  // Loading ends on the flagged word or when the array is full.
  assign load_end = bus.load_last || (ptr == ADDR_W'(DEPTH - 1));
  assign cpu_wr   = (state == RUN) && !bus.CEN && !bus.WEN;
  assign cpu_rd   = (state == RUN) && !bus.CEN && bus.WEN && !bus.OEN;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    if (load_acc && load_end) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: all derived from registered state, so reset forces them at once.
  always_comb begin
    bus.load_ready = (state == LOAD);
    cpu_hold       = (state != RUN);
    bus.Q          = '0;
    if (cpu_rd && in_range) begin
      bus.Q = mem[bus.A];
    end
  end

  // Array and load pointer. Load and CPU writes are exclusive by state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (load_acc) begin
        mem[ptr] <= bus.load_data;
        ptr      <= ptr + 1'b1;
      end else if (cpu_wr && in_range) begin
        mem[bus.A] <= bus.D;
      end
    end
  end

  // Access counters, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (cpu_rd && (rd_count != {CNT_W{1'b1}})) begin
        rd_count <= rd_count + CNT_W'(1);
      end
      if (cpu_wr && (wr_count != {CNT_W{1'b1}})) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder

module tb_dmem_responder;

  localparam int MDEPTH = 128;
  localparam int CMAX   = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic        hold1;
  logic        hold2;
  logic [15:0] rd1;
  logic [15:0] wr1;
  logic [1:0]  rd2;
  logic [1:0]  wr2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(7)) b1 ();
  dmem_responder_if #(.ADDR_W(7)) b2 ();

  dmem_responder #(.ADDR_W(7), .DEPTH(128), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (b1.slave),
    .cpu_hold (hold1),
    .rd_count (rd1),
    .wr_count (wr1)
  );

  dmem_responder #(.ADDR_W(7), .DEPTH(128), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst      (rst2),
    .bus      (b2.slave),
    .cpu_hold (hold2),
    .rd_count (rd2),
    .wr_count (wr2)
  );

  // Reference model: phase 0 = waiting, 1 = loading, 2 = serving the CPU.
  int          m_phase;
  int          m_ptr;
  int          m_rd;
  int          m_wr;
  logic [31:0] m_mem [MDEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_phase = 0;
    m_ptr   = 0;
    m_rd    = 0;
    m_wr    = 0;
    for (int i = 0; i < MDEPTH; i++) m_mem[i] = '0;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: if (b1.load_valid) begin
             m_mem[m_ptr] = b1.load_data;
             if (b1.load_last || m_ptr == MDEPTH - 1) m_phase = 2;
             m_ptr++;
           end
        default: begin
          if (!b1.CEN && !b1.WEN) begin
            if (int'(b1.A) < MDEPTH) m_mem[b1.A] = b1.D;
            if (m_wr < CMAX) m_wr++;
          end
          if (!b1.CEN && b1.WEN && !b1.OEN && m_rd < CMAX) m_rd++;
        end
      endcase
    end
    #1;
  endtask

  task automatic check_model(input string pre);
    logic [31:0] exp_q;
    exp_q = (m_phase == 2 && !b1.CEN && b1.WEN && !b1.OEN) ? m_mem[b1.A] : 32'h0;
    check({pre, "_q"},     b1.Q,              exp_q);
    check({pre, "_ready"}, 32'(b1.load_ready), 32'(m_phase == 1));
    check({pre, "_hold"},  32'(hold1),        32'(m_phase != 2));
    check({pre, "_rd"},    32'(rd1),          32'(m_rd));
    check({pre, "_wr"},    32'(wr1),          32'(m_wr));
  endtask

  task automatic set_cpu(input bit cen, input bit wen, input bit oen, input int a, input logic [31:0] d);
    b1.CEN = cen;
    b1.WEN = wen;
    b1.OEN = oen;
    b1.A   = 7'(a);
    b1.D   = d;
  endtask

  task automatic set_load(input bit v, input logic [31:0] data, input bit last);
    b1.load_valid = v;
    b1.load_data  = data;
    b1.load_last  = last;
  endtask

  // One full cycle: drive, settle, compare against the model, clock.
  task automatic cyc(input string pre);
    #2;
    check_model(pre);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int loaded;
    int a;
    model_clear();
    rst  = 1'b1;
    rst2 = 1'b1;
    set_cpu(1, 1, 1, 0, 0);
    set_load(0, 0, 0);
    b2.CEN = 1'b1; b2.WEN = 1'b1; b2.OEN = 1'b1; b2.A = '0; b2.D = '0;
    b2.load_valid = 1'b0; b2.load_data = '0; b2.load_last = 1'b0;

    // Reset state, with a CPU read pattern applied to prove Q stays 0.
    tick(); tick();
    set_cpu(0, 1, 0, 3, 0);
    #2;
    check("rst_q",     b1.Q,              32'h0);
    check("rst_ready", 32'(b1.load_ready), 32'h0);
    check("rst_hold",  32'(hold1),        32'h1);
    check("rst_rd",    32'(rd1),          32'h0);
    check("rst_wr",    32'(wr1),          32'h0);
    set_cpu(1, 1, 1, 0, 0);
    tick();

    // Release: load_ready appears after the first edge.
    rst = 1'b0;
    #2;
    check("rel_ready0", 32'(b1.load_ready), 32'h0);
    tick();
    #2;
    check("rel_ready1", 32'(b1.load_ready), 32'h1);

    // Three-word load with a stall and an ignored CPU write to A=4.
    set_load(1, 32'h11, 0);            cyc("ld0");
    set_load(0, 32'h99, 1);            cyc("ld_stall");
    set_load(1, 32'h22, 0);
    set_cpu(0, 0, 1, 4, 32'hFFFF_FFFF);
    #2;
    check("ld_cpuwr_q",  b1.Q,       32'h0);
    check("ld_cpuwr_wr", 32'(wr1),   32'h0);
    cyc("ld1");
    set_cpu(1, 1, 1, 0, 0);
    set_load(1, 32'h33, 1);
    #2;
    check("ld_last_hold_before", 32'(hold1), 32'h1);
    cyc("ld2");
    set_load(0, 0, 0);
    #2;
    check("ld_last_hold_after", 32'(hold1),        32'h0);
    check("ld_last_ready",      32'(b1.load_ready), 32'h0);

    // Write then read back; then the same read with output disabled.
    set_cpu(0, 0, 1, 5, 32'hDEAD_BEEF); cyc("wr5");
    set_cpu(0, 1, 0, 5, 0);
    #2;
    check("rd5_q",  b1.Q,      32'hDEAD_BEEF);
    check("rd5_wr", 32'(wr1),  32'h1);
    tick();
    check("rd5_rd", 32'(rd1),  32'h1);
    set_cpu(0, 1, 1, 5, 0);
    #2;
    check("rd5_oen_q", b1.Q, 32'h0);
    tick();
    check("rd5_oen_rd", 32'(rd1), 32'h1);

    // Reads of the loaded image; A=3 and A=4 were never loaded.
    for (int i = 0; i < 5; i++) begin
      logic [31:0] img [5];
      img = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
      set_cpu(0, 1, 0, i, 0);
      #2;
      check($sformatf("img_rd%0d", i), b1.Q, img[i]);
      tick();
    end

    // Randomized traffic in RUN, biased to low addresses for read-after-write.
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 127);
      set_cpu($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0, a, $urandom);
      set_load($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      cyc("run");
    end
    set_load(0, 0, 0);

    // Write A=7, then an asynchronous reset in the middle of a read.
    set_cpu(0, 0, 1, 7, 32'h77); cyc("wr7");
    set_cpu(0, 1, 0, 7, 0);
    #2;
    check("rd7_q", b1.Q, 32'h77);
    #1;
    rst = 1'b1;
    #1;
    check("arst_q",    b1.Q,       32'h0);
    check("arst_hold", 32'(hold1), 32'h1);
    check("arst_rd",   32'(rd1),   32'h0);
    check("arst_wr",   32'(wr1),   32'h0);
    model_clear();
    set_cpu(1, 1, 1, 0, 0);
    tick(); tick();
    rst = 1'b0;
    cyc("rel2");
    set_load(1, 32'hAB, 1); cyc("reload");
    set_load(0, 0, 0);
    set_cpu(0, 1, 0, 7, 0);
    #2;
    check("reload_rd7", b1.Q, 32'h0);
    cyc("reload_rd7m");
    set_cpu(0, 1, 0, 0, 0);
    #2;
    check("reload_rd0", b1.Q, 32'hAB);
    cyc("reload_rd0m");

    // Full 128-word load without load_last, random stalls and CPU noise.
    rst = 1'b1;
    set_cpu(1, 1, 1, 0, 0);
    tick();
    rst = 1'b0;
    cyc("rel3");
    loaded = 0;
    for (int it = 0; it < 2000 && loaded < MDEPTH; it++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      set_load(v, 32'(loaded), 1'b0);
      if (loaded > 10 && loaded < 14)
        set_cpu(0, 0, 1, 4, 32'hFFFF_FFFF);
      else
        set_cpu($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 127), $urandom);
      cyc("full");
      if (v) loaded++;
    end
    check("full_count", 32'(loaded), 32'(MDEPTH));
    set_cpu(1, 1, 1, 0, 0);
    set_load(1, 32'hBAD, 1);
    #2;
    check("full_ready", 32'(b1.load_ready), 32'h0);
    check("full_hold",  32'(hold1),         32'h0);
    check("full_wr",    32'(wr1),           32'h0);
    cyc("full_extra");
    set_load(0, 0, 0);
    for (int i = MDEPTH - 1; i >= 0; i--) begin
      set_cpu(0, 1, 0, i, 0);
      #2;
      check($sformatf("full_rd%0d", i), b1.Q, 32'(i));
      cyc("full_rdm");
    end

    // Narrow-counter instance: five reads and five writes saturate at 3.
    rst = 1'b1;
    set_cpu(1, 1, 1, 0, 0);
    rst2 = 1'b0;
    tick();
    b2.load_valid = 1'b1; b2.load_data = 32'h5; b2.load_last = 1'b1;
    tick();
    b2.load_valid = 1'b0;
    #2;
    check("sat_hold", 32'(hold2), 32'h0);
    b2.CEN = 1'b0; b2.WEN = 1'b1; b2.OEN = 1'b0; b2.A = '0;
    for (int k = 1; k <= 5; k++) begin
      #2;
      check($sformatf("sat_q%0d", k), b2.Q, 32'h5);
      tick();
      check($sformatf("sat_rd%0d", k), 32'(rd2), 32'((k < 3) ? k : 3));
    end
    b2.WEN = 1'b0; b2.D = 32'h9;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("sat_wr%0d", k), 32'(wr2), 32'((k < 3) ? k : 3));
    end
    b2.CEN = 1'b1;
    check("sat_rd_final", 32'(rd2), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
